// File: rtl/wb_rf_write_scheduler.sv
// wb_rf_write_scheduler: arbitrates the single register-file write port between
// the in-order pipeline writeback and a buffered long-latency result stream.
// Optional macro WB_RF_SCHED_FWD_EN adds a combinational forwarding lookup
// into the buffer (fwd_addr/fwd_hit/fwd_data).
module wb_rf_write_scheduler #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [6:0]               pipe_addr,
  input  logic [31:0]              pipe_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [6:0]               lu_addr,
  input  logic [31:0]              lu_data,
  output logic                     stall_pipe,
  output logic                     rf_we,
  output logic [6:0]               rf_addr,
  output logic [31:0]              rf_data,
  output logic [$clog2(DEPTH):0]   pending_cnt
`ifdef WB_RF_SCHED_FWD_EN
  ,
  input  logic [6:0]               fwd_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned SW     = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic full_c, empty_c, push_c, pop_c, pipe_grant_c, stall_c;

  // Handshake, stall and slot decision, all from registered occupancy.
  always_comb begin
    full_c       = (cnt_q == CW'(DEPTH));
    empty_c      = (cnt_q == '0);
    stall_c      = (starve_q == SW'(STARVE_LIMIT)) && !empty_c;
    push_c       = lu_valid && !full_c && (lu_addr != '0);
    pipe_grant_c = !stall_c && pipe_we && (pipe_addr != '0);
    pop_c        = !empty_c && !pipe_grant_c;
  end

  assign lu_ready    = !full_c;
  assign stall_pipe  = stall_c;
  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign pending_cnt = cnt_q;

  // Next-state for pointers, valid bits, occupancy, starvation and write port.
  always_comb begin
    vld_d     = vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CW'(push_c) - CW'(pop_c);
    starve_d  = starve_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;

    // A granted pipeline write is younger than anything buffered.
    if (pipe_grant_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == pipe_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop_c) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end
    if (push_c) begin
      vld_d[wr_ptr_q] = !(pipe_grant_c && (lu_addr == pipe_addr));
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (empty_c || pop_c) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end

    if (pipe_grant_c) begin
      rf_we_d   = 1'b1;
      rf_addr_d = pipe_addr;
      rf_data_d = pipe_data;
    end else if (pop_c && vld_q[rd_ptr_q]) begin
      rf_we_d   = 1'b1;
      rf_addr_d = addr_q[rd_ptr_q];
      rf_data_d = data_q[rd_ptr_q];
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Buffer payload storage; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[wr_ptr_q] <= lu_addr;
      data_q[wr_ptr_q] <= lu_data;
    end
  end

`ifdef WB_RF_SCHED_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest valid match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + AW'(k);
      if ((CW'(k) < cnt_q) && vld_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr) &&
          (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_rf_write_scheduler.sv
// Directed bench for wb_rf_write_scheduler (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [6:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [6:0]  lu_addr;
  logic [31:0] lu_data;
  logic        stall_pipe;
  logic        rf_we;
  logic [6:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  pending_cnt;
`ifdef WB_RF_SCHED_FWD_EN
  logic [6:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_rf_write_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_addr    (lu_addr),
    .lu_data    (lu_data),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .pending_cnt(pending_cnt)
`ifdef WB_RF_SCHED_FWD_EN
    ,
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we   = 1'b0;
    pipe_addr = 7'd0;
    pipe_data = 32'd0;
    lu_valid  = 1'b0;
    lu_addr   = 7'd0;
    lu_data   = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    total++; if (rf_addr !== 7'd0) begin bad++; $display("FAIL reset_rf_addr got=%0d exp=0", rf_addr); end
    total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
    total++; if (pending_cnt !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending_cnt); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_lu_ready got=%0b exp=1", lu_ready); end
    total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_pipe); end
  endtask

  // lu result drains into an idle slot; pipe_we with addr 0 does not claim it.
  task automatic test_drain();
    lu_valid = 1'b1; lu_addr = 7'd5; lu_data = 32'hAAAA0001;
    tick();
    idle_inputs();
    total++; if (pending_cnt !== 2'd1) begin bad++; $display("FAIL drain_pending1 got=%0d exp=1", pending_cnt); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_we_before got=%0b exp=0", rf_we); end
    pipe_we = 1'b1; pipe_addr = 7'd0; pipe_data = 32'hDEAD0000;
    tick();
    idle_inputs();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL drain_we got=%0b exp=1", rf_we); end
    total++; if (rf_addr !== 7'd5) begin bad++; $display("FAIL drain_addr got=%0d exp=5", rf_addr); end
    total++; if (rf_data !== 32'hAAAA0001) begin bad++; $display("FAIL drain_data got=%h exp=aaaa0001", rf_data); end
    total++; if (pending_cnt !== 2'd0) begin bad++; $display("FAIL drain_pending0 got=%0d exp=0", pending_cnt); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_idle_we got=%0b exp=0", rf_we); end
    total++; if (rf_addr !== 7'd5) begin bad++; $display("FAIL drain_idle_hold got=%0d exp=5", rf_addr); end
  endtask

  task automatic test_starve();
    pipe_we = 1'b1; pipe_addr = 7'd3; pipe_data = 32'h00000333;
    lu_valid = 1'b1; lu_addr = 7'd8; lu_data = 32'h00000088;
    tick();
    lu_valid = 1'b0;
    total++; if (rf_addr !== 7'd3 || rf_we !== 1'b1) begin bad++; $display("FAIL starve_pipe_wr got=%0d/%0b exp=3/1", rf_addr, rf_we); end
    for (int c = 1; c <= 4; c++) begin
      total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL starve_early_stall c=%0d got=%0b exp=0", c, stall_pipe); end
      tick();
    end
    total++; if (stall_pipe !== 1'b1) begin bad++; $display("FAIL starve_stall got=%0b exp=1", stall_pipe); end
    tick();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL starve_drain_we got=%0b exp=1", rf_we); end
    total++; if (rf_addr !== 7'd8) begin bad++; $display("FAIL starve_drain_addr got=%0d exp=8", rf_addr); end
    total++; if (rf_data !== 32'h00000088) begin bad++; $display("FAIL starve_drain_data got=%h exp=88", rf_data); end
    total++; if (stall_pipe !== 1'b0) begin bad++; $display("FAIL starve_release got=%0b exp=0", stall_pipe); end
    tick();
    total++; if (rf_addr !== 7'd3) begin bad++; $display("FAIL starve_pipe_resume got=%0d exp=3", rf_addr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_kill();
    pipe_we = 1'b1; pipe_addr = 7'd1; pipe_data = 32'h55;
    lu_valid = 1'b1; lu_addr = 7'd9; lu_data = 32'h11;
    tick();
    lu_valid = 1'b0;
    pipe_addr = 7'd9; pipe_data = 32'h22;
    tick();
    pipe_we = 1'b0;
    total++; if (rf_addr !== 7'd9 || rf_data !== 32'h22) begin bad++; $display("FAIL kill_pipe got=%0d/%h exp=9/22", rf_addr, rf_data); end
    total++; if (pending_cnt !== 2'd1) begin bad++; $display("FAIL kill_pending1 got=%0d exp=1", pending_cnt); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL kill_pop_we got=%0b exp=0", rf_we); end
    total++; if (rf_data !== 32'h22) begin bad++; $display("FAIL kill_hold_data got=%h exp=22", rf_data); end
    total++; if (pending_cnt !== 2'd0) begin bad++; $display("FAIL kill_pending0 got=%0d exp=0", pending_cnt); end
    // Same-cycle push and pipeline write to one address: the push lands killed.
    pipe_we = 1'b1; pipe_addr = 7'd6; pipe_data = 32'h66;
    lu_valid = 1'b1; lu_addr = 7'd6; lu_data = 32'h77;
    tick();
    idle_inputs();
    total++; if (rf_data !== 32'h66 || pending_cnt !== 2'd1) begin bad++; $display("FAIL kill_same got=%h/%0d exp=66/1", rf_data, pending_cnt); end
    tick();
    total++; if (rf_we !== 1'b0 || rf_data !== 32'h66) begin bad++; $display("FAIL kill_same_pop got=%0b/%h exp=0/66", rf_we, rf_data); end
    // lu_addr 0 is accepted but never stored.
    lu_valid = 1'b1; lu_addr = 7'd0; lu_data = 32'h99;
    tick();
    idle_inputs();
    total++; if (pending_cnt !== 2'd0) begin bad++; $display("FAIL zero_addr_pending got=%0d exp=0", pending_cnt); end
  endtask

  task automatic test_full();
    pipe_we = 1'b1; pipe_addr = 7'd3; pipe_data = 32'h333;
    lu_valid = 1'b1; lu_addr = 7'd10; lu_data = 32'hA0;
    tick();
    lu_addr = 7'd11; lu_data = 32'hB0;
    tick();
    lu_addr = 7'd12; lu_data = 32'hC0;
    total++; if (pending_cnt !== 2'd2) begin bad++; $display("FAIL full_pending got=%0d exp=2", pending_cnt); end
    for (int c = 2; c <= 4; c++) begin
      total++; if (lu_ready !== 1'b0 || stall_pipe !== 1'b0) begin bad++; $display("FAIL full_wait c=%0d got=%0b/%0b exp=0/0", c, lu_ready, stall_pipe); end
      tick();
    end
    total++; if (stall_pipe !== 1'b1 || lu_ready !== 1'b0) begin bad++; $display("FAIL full_stall got=%0b/%0b exp=1/0", stall_pipe, lu_ready); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_addr !== 7'd10) begin bad++; $display("FAIL full_drain got=%0b/%0d exp=1/10", rf_we, rf_addr); end
    total++; if (pending_cnt !== 2'd1) begin bad++; $display("FAIL full_no_accept got=%0d exp=1", pending_cnt); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL full_ready got=%0b exp=1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    total++; if (pending_cnt !== 2'd2) begin bad++; $display("FAIL full_accept got=%0d exp=2", pending_cnt); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%0b exp=0", rf_we); end
    total++; if (pending_cnt !== 2'd0) begin bad++; $display("FAIL rstmid_pending got=%0d exp=0", pending_cnt); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b exp=1", lu_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_no_write c=%0d got=%0b exp=0", c, rf_we); end
    end
  endtask

`ifdef WB_RF_SCHED_FWD_EN
  task automatic test_fwd();
    fwd_addr = 7'd4;
    pipe_we = 1'b1; pipe_addr = 7'd3; pipe_data = 32'h333;
    lu_valid = 1'b1; lu_addr = 7'd4; lu_data = 32'h10;
    tick();
    lu_data = 32'h20;
    tick();
    lu_valid = 1'b0;
    total++; if (fwd_hit !== 1'b1) begin bad++; $display("FAIL fwd_hit got=%0b exp=1", fwd_hit); end
    total++; if (fwd_data !== 32'h20) begin bad++; $display("FAIL fwd_data got=%h exp=20", fwd_data); end
    fwd_addr = 7'd7;
    #1;
    total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss got=%0b exp=0", fwd_hit); end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
`ifdef WB_RF_SCHED_FWD_EN
    fwd_addr = 7'd0;
`endif
    test_reset();
    test_drain();
    test_starve();
    test_kill();
    test_full();
    test_reset_mid();
`ifdef WB_RF_SCHED_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
